// File: rtl/ternary_mvm_if.sv
// Byte-stream input and multiplier-facing outputs of the ternary MVM sequencer.
// master = sequencer side, slave = stream source / multiplier side.
interface ternary_mvm_if #(
    parameter int InLen    = 14,
    parameter int BitWidth = 8
);
    logic                    start;
    logic [7:0]              in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [2*InLen-1:0]      W;
    logic [2*BitWidth-1:0]   VecIn;
    logic [2:0]              row;
    logic                    vec_valid;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, in_data, in_valid,
        output in_ready, W, VecIn, row, vec_valid, busy, done
    );

    modport slave (
        output start, in_data, in_valid,
        input  in_ready, W, VecIn, row, vec_valid, busy, done
    );
endinterface

// File: rtl/ternary_mvm_sequencer.sv
// Feeds the ternary MVM stage: loads one canonicalised weight word, then
// issues NumRows {element1, element0} pairs with a row index, then pulses done.
module ternary_mvm_sequencer #(
    parameter int InLen    = 14,
    parameter int BitWidth = 8,
    parameter int NumRows  = 8
) (
    input  logic           clk,
    input  logic           rst,
    ternary_mvm_if.master  bus
);
    localparam int WW       = 2 * InLen;
    localparam int NumBytes = (WW + 7) / 8;
    localparam int BufW     = NumBytes * 8;
    localparam int CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [CntW-1:0] LastByte = CntW'(NumBytes - 1);
    localparam logic [2:0]      LastRow  = 3'(NumRows - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_RUN_LO = 3'd2,
        S_RUN_HI = 3'd3,
        S_ISSUE  = 3'd4
    } state_e;

    // Ternary weights use 00/01/10; the redundant 11 code is folded onto -1.
    function automatic logic [7:0] canon_byte(input logic [7:0] b);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 4; i++) begin
            c[2*i +: 2] = (b[2*i +: 2] == 2'b11) ? 2'b10 : b[2*i +: 2];
        end
        return c;
    endfunction

    state_e                 state_q, state_d;
    logic [CntW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [BufW-1:0]        wbuf_q, wbuf_d;
    logic [WW-1:0]          w_q, w_d;
    logic [BitWidth-1:0]    elem0_q, elem0_d, elem1_q, elem1_d;
    logic [2*BitWidth-1:0]  vec_q, vec_d;
    logic [2:0]             row_q, row_d, row_cnt_q, row_cnt_d;
    logic                   vec_valid_q, vec_valid_d;
    logic                   done_q, done_d;
    logic                   last_q, last_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;
    logic                   xfer_s;

    assign xfer_s        = in_ready_q & bus.in_valid;
    assign bus.in_ready  = in_ready_q;
    assign bus.W         = w_q;
    assign bus.VecIn     = vec_q;
    assign bus.row       = row_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = bus.start ? S_LOAD_W : S_IDLE;
            S_LOAD_W: state_d = (xfer_s && (byte_cnt_q == LastByte)) ? S_RUN_LO : S_LOAD_W;
            S_RUN_LO: state_d = xfer_s ? S_RUN_HI : S_RUN_LO;
            S_RUN_HI: state_d = xfer_s ? S_ISSUE : S_RUN_HI;
            S_ISSUE:  state_d = (row_cnt_q == LastRow) ? S_IDLE : S_RUN_LO;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        wbuf_d      = wbuf_q;
        w_d         = w_q;
        elem0_d     = elem0_q;
        elem1_d     = elem1_q;
        vec_d       = vec_q;
        row_d       = row_q;
        row_cnt_d   = row_cnt_q;
        vec_valid_d = 1'b0;
        done_d      = 1'b0;
        last_d      = 1'b0;
        in_ready_d  = (state_d == S_LOAD_W) || (state_d == S_RUN_LO) || (state_d == S_RUN_HI);
        busy_d      = (state_d != S_IDLE);

        // The row wrap to 0 coincides with done so downstream publishes results.
        if (last_q) begin
            done_d = 1'b1;
            row_d  = 3'd0;
        end else begin
            done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    byte_cnt_d = '0;
                end else begin
                    byte_cnt_d = byte_cnt_q;
                end
            end
            S_LOAD_W: begin
                if (xfer_s) begin
                    wbuf_d[{byte_cnt_q, 3'b000} +: 8] = canon_byte(bus.in_data);
                    if (byte_cnt_q == LastByte) begin
                        w_d        = wbuf_d[WW-1:0];
                        byte_cnt_d = '0;
                        row_cnt_d  = 3'd0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CntW'(1);
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q;
                end
            end
            S_RUN_LO: begin
                if (xfer_s) begin
                    elem0_d = BitWidth'(bus.in_data);
                end else begin
                    elem0_d = elem0_q;
                end
            end
            S_RUN_HI: begin
                if (xfer_s) begin
                    elem1_d = BitWidth'(bus.in_data);
                end else begin
                    elem1_d = elem1_q;
                end
            end
            S_ISSUE: begin
                vec_d       = {elem1_q, elem0_q};
                row_d       = row_cnt_q;
                vec_valid_d = 1'b1;
                if (row_cnt_q == LastRow) begin
                    last_d    = 1'b1;
                    row_cnt_d = 3'd0;
                end else begin
                    row_cnt_d = row_cnt_q + 3'd1;
                end
            end
            default: begin
                byte_cnt_d = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q  <= '0;
            wbuf_q      <= '0;
            w_q         <= '0;
            elem0_q     <= '0;
            elem1_q     <= '0;
            vec_q       <= '0;
            row_q       <= 3'd0;
            row_cnt_q   <= 3'd0;
            vec_valid_q <= 1'b0;
            done_q      <= 1'b0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            wbuf_q      <= wbuf_d;
            w_q         <= w_d;
            elem0_q     <= elem0_d;
            elem1_q     <= elem1_d;
            vec_q       <= vec_d;
            row_q       <= row_d;
            row_cnt_q   <= row_cnt_d;
            vec_valid_q <= vec_valid_d;
            done_q      <= done_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_ternary_mvm_sequencer.sv
// Directed bench for ternary_mvm_sequencer: reset, weight load, full/stalled/
// aborted passes and an ignored start, with a queue scoreboard for VecIn/row.
module tb_ternary_mvm_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   vv_cnt  = 0;
    int   done_cnt = 0;
    int   last_vv = -1;
    logic spacing_on = 1'b0;
    logic prev_row7  = 1'b0;
    logic [18:0] exp_q[$];

    ternary_mvm_if #(.InLen(14), .BitWidth(8)) bus ();

    ternary_mvm_sequencer #(.InLen(14), .BitWidth(8), .NumRows(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [27:0] w_model(input logic [7:0] b0, b1, b2, b3);
        logic [31:0] raw;
        logic [27:0] w;
        logic [1:0]  pr;
        raw = {b3, b2, b1, b0};
        for (int i = 0; i < 14; i++) begin
            pr = raw[2*i +: 2];
            w[2*i +: 2] = (pr == 2'b11) ? 2'b10 : pr;
        end
        return w;
    endfunction

    // Scoreboard monitor on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.vec_valid) begin
                vv_cnt++;
                if (exp_q.size() == 0) chk("vec_unexpected", 32'(exp_q.size()), 32'd1);
                else                   chk("vec", {13'd0, bus.row, bus.VecIn}, {13'd0, exp_q.pop_front()});
                if (spacing_on && last_vv >= 0) chk("vv_spacing", 32'(cyc - last_vv), 32'd3);
                last_vv = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_row", {29'd0, bus.row}, 32'd0);
                chk("done_after_row7", {31'd0, prev_row7}, 32'd1);
            end
            prev_row7 = bus.vec_valid && (bus.row == 3'd7);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_wait", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic load_w(input logic [7:0] b0, b1, b2, b3, input logic [27:0] w_before);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        chk("w_held_before_last", {4'd0, bus.W}, {4'd0, w_before});
        send_byte(b3);
        chk("w_loaded", {4'd0, bus.W}, {4'd0, w_model(b0, b1, b2, b3)});
    endtask

    task automatic run_rows(input logic [7:0] base, input int stall_row, input int ign_row, input int abort_row);
        logic [7:0] e0, e1;
        int n;
        for (int r = 0; r < 8; r++) begin
            e0 = base + 8'(2*r);
            e1 = base + 8'(2*r + 1);
            if (r == ign_row) begin
                n = 0;
                while (!bus.in_ready && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                chk("ign_start_busy", {31'd0, bus.busy}, 32'd1);
                chk("ign_start_ready", {31'd0, bus.in_ready}, 32'd1);
            end
            send_byte(e0);
            if (r == abort_row) return;
            if (r == stall_row) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_row", {29'd0, bus.row}, 32'(r - 1));
                    chk("stall_vec", {16'd0, bus.VecIn}, {16'd0, e0 - 8'd1, e0 - 8'd2});
                    chk("stall_vv", {31'd0, bus.vec_valid}, 32'd0);
                end
            end
            exp_q.push_back({3'(r), e1, e0});
            send_byte(e1);
        end
    endtask

    task automatic wait_done(input logic [15:0] vec_last, input logic [27:0] w_exp);
        int n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, bus.done}, 32'd1);
        chk("done_vec_hold", {16'd0, bus.VecIn}, {16'd0, vec_last});
        chk("done_w_hold", {4'd0, bus.W}, {4'd0, w_exp});
        chk("done_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("done_pulse_1cyc", {31'd0, bus.done}, 32'd0);
        chk("vv_count", 32'(vv_cnt), 32'd8);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [27:0] wa, wb;
        wa = w_model(8'h1B, 8'hE4, 8'hFF, 8'h3C);
        wb = w_model(8'h55, 8'hAA, 8'h0F, 8'hF0);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {bus.W, bus.row, bus.in_ready},
            {31'd0, 1'b0});
        chk("rst_vec", {16'd0, bus.VecIn}, 32'd0);
        chk("rst_flags", {29'd0, bus.vec_valid, bus.busy, bus.done}, 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        bus.in_valid = 1'b0;

        // Pass 1: weight load then back-to-back full pass.
        do_start();
        chk("weight0_spot", {30'd0, wa[1:0]}, 32'd2);
        load_w(8'h1B, 8'hE4, 8'hFF, 8'h3C, 28'd0);
        vv_cnt = 0; done_cnt = 0; last_vv = -1; spacing_on = 1'b1;
        run_rows(8'h01, -1, -1, -1);
        wait_done(16'h100F, wa);
        spacing_on = 1'b0;

        // Pass 2: stall between element0 and element1 of row 3.
        do_start();
        load_w(8'h1B, 8'hE4, 8'hFF, 8'h3C, wa);
        vv_cnt = 0; done_cnt = 0;
        run_rows(8'h01, 3, -1, -1);
        wait_done(16'h100F, wa);

        // Pass 3: reset while waiting for element1 of row 5.
        do_start();
        load_w(8'h1B, 8'hE4, 8'hFF, 8'h3C, wa);
        vv_cnt = 0; done_cnt = 0;
        run_rows(8'h01, -1, -1, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_row", {29'd0, bus.row}, 32'd0);
        chk("abort_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("abort_vv_count", 32'(vv_cnt), 32'd5);
        chk("abort_scoreboard", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Pass 4: clean load and run after abort, signed-looking elements.
        do_start();
        load_w(8'h55, 8'hAA, 8'h0F, 8'hF0, 28'd0);
        vv_cnt = 0; done_cnt = 0;
        run_rows(8'h80, -1, -1, -1);
        wait_done(16'h8F8E, wb);

        // Pass 5: start pulsed during RUN_LO of row 1 is ignored.
        do_start();
        load_w(8'h1B, 8'hE4, 8'hFF, 8'h3C, wb);
        vv_cnt = 0; done_cnt = 0;
        run_rows(8'h01, -1, 1, -1);
        wait_done(16'h100F, wa);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
